multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle RV32 control FSM; successor to the single-cycle combinational decoder.
//  Latches each fetched instruction and sequences it through FETCH/DECODE/EXEC/MEM/WB.
//  Waits on imem/dmem ready handshakes, with a timeout and an illegal-instruction trap.
//  Counts retired instructions. Sits between the memories and the shared datapath (ALU, regfile, PC).
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for imem_ready/dmem_ready; 0 disables timeout
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      leave IDLE and begin fetching; ignored outside IDLE
//  imem_rdata  in   32     instruction word, valid when imem_ready=1
//  imem_ready  in   1      instruction memory ack
//  dmem_ready  in   1      data memory ack (load data valid / store accepted)
//  zero        in   1      ALU result == 0
//  signed_bit  in   1      ALU result sign (rs1 < rs2 after sub)
//  imem_req    out  1      instruction fetch request
//  dmem_req    out  1      data memory request
//  dmem_we     out  1      1 = store, 0 = load (qualified by dmem_req)
//  instr       out  32     latched instruction register (to regfile/immgen)
//  alu_op      out  4      0000 and, 0001 or, 0010 xor, 0011 sll, 0100 srl, 0101 add, 0110 sub
//  alu_src     out  1      1 = immediate operand B
//  shift_i     out  1      1 = slli/srli shamt operand
//  reg_we      out  1      register file write enable
//  mem_to_reg  out  1      1 = writeback from load data
//  write_pc4   out  1      1 = writeback PC+4 (jal/jalr)
//  pc_we       out  1      PC update strobe (one cycle per retired instruction)
//  pc_src      out  1      1 = branch/jump target, 0 = PC+4
//  jalr        out  1      1 = target from ALU (rs1+imm)
//  state       out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6
//  trap        out  1      sticky fault flag
//  trap_cause  out  2      0 none, 1 illegal instruction, 2 imem timeout, 3 dmem timeout
//  instret     out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, instr=0, instret=0, trap=0, trap_cause=0, timeout counter=0.
//   All strobes are 0 while in reset; in-flight instruction is abandoned, no partial retire.
//  Outputs are decoded combinationally from state+instr. Strobes are 0 outside their listed state.
//  IDLE: start=1 -> FETCH.
//  FETCH: imem_req=1. imem_ready=1 -> instr<=imem_rdata, -> DECODE.
//  DECODE (1 cycle): supported ops are R add/sub/and/or/xor/sll/srl, I addi/xori/ori/andi/slli/srli,
//   lw(f3=010), sw(f3=010), beq/bne/blt/bge, jal, jalr(f3=000). Any other encoding -> TRAP, cause 1.
//  EXEC: drive alu_op/alu_src/shift_i.
//   Branches use alu_op=sub. pc_we=1; pc_src=taken; -> FETCH.
//    taken: beq zero; bne !zero; blt !zero&&signed_bit; bge !signed_bit.
//   jal/jalr: reg_we=1, write_pc4=1, pc_we=1, pc_src=1, jalr=(jalr op); -> FETCH.
//   lw/sw: alu_op=add, alu_src=1 -> MEM. R/I ALU ops -> WB.
//  MEM: dmem_req=1, dmem_we=(sw). Hold alu_op/alu_src. On dmem_ready: lw -> WB.
//   sw -> pc_we=1, pc_src=0, -> FETCH (same cycle).
//  WB: reg_we=1, mem_to_reg=(lw), ALU controls held; pc_we=1, pc_src=0; -> FETCH.
//  Latency with zero-wait memories: branch/jal/jalr 3 cycles, ALU/sw 4, lw 5 (FETCH entry to next FETCH).
//  Timeout: counter clears on entering FETCH/MEM and increments each waiting cycle.
//   If ready not seen within MEM_TIMEOUT cycles -> TRAP (cause 2 in FETCH, 3 in MEM).
//   Ready on the final allowed cycle wins over timeout. MEM_TIMEOUT=0: wait forever.
//  TRAP: trap=1; trap_cause held; all strobes 0; exit only by reset. start ignored.
//  instret += 1 on every cycle with pc_we=1; wraps modulo 2^CNT_W without flag.
//  A memory ready arriving outside FETCH/MEM is ignored.
// TESTING
//  1 reset, start, addi x1,x0,5 (0x00500093), zero-wait -> states 1,2,3,5,1; reg_we@WB; alu_op=0101; instret=1.
//  2 lw 0x0000A103, dmem_ready after 3 waits -> dmem_req held 4 cycles, dmem_we=0; WB mem_to_reg=1.
//  3 beq with zero=1, then bne with zero=1 -> pc_src=1 then 0; each pc_we 1 cycle, no reg_we, alu_op=0110.
//  4 fetch 0xFFFFFFFF -> TRAP cause 1, trap sticky, all strobes 0, instret unchanged; rst_n low clears.
//  5 MEM_TIMEOUT=4, imem_ready never -> TRAP cause 2 after 4 cycles; repeat with ready on 4th cycle -> DECODE.
//  6 rst_n low mid-MEM on sw -> immediate IDLE, dmem_req=0, no pc_we; CNT_W=2, 4 retires -> instret wraps to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Memory-side handshake bundle for the multi-cycle control FSM.
// Carries the instruction-fetch request/response and the data-memory
// request/ack so the controller and the memory models share one port.
//   imem_req    controller -> imem   fetch request
//   imem_rdata  imem -> controller   instruction word (valid with imem_ready)
//   imem_ready  imem -> controller   fetch acknowledge
//   dmem_req    controller -> dmem   data access request
//   dmem_we     controller -> dmem   1 = store, 0 = load
//   dmem_ready  dmem -> controller   load data valid / store accepted
// master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface multicycle_control_if;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_rdata,
      input  imem_ready,
      input  dmem_ready
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_rdata,
      output imem_ready,
      output dmem_ready
   );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle RV32 control FSM. Latches each fetched instruction and walks it
// through FETCH/DECODE/EXEC/MEM/WB, waiting on the memory handshakes with a
// bounded wait and trapping on unsupported encodings. Counts retirements.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem               memory handshake bundle (master side)
//   i_start           leave IDLE and start fetching
//   i_zero            ALU result == 0
//   i_signed_bit      ALU result sign (rs1 < rs2 after sub)
//   o_instr           latched instruction register
//   o_alu_op          ALU operation select
//   o_alu_src         1 = immediate operand B
//   o_shift_i         1 = shamt operand (slli/srli)
//   o_reg_we          register file write enable
//   o_mem_to_reg      1 = write back load data
//   o_write_pc4       1 = write back PC+4
//   o_pc_we           PC update strobe, one cycle per retired instruction
//   o_pc_src          1 = branch/jump target
//   o_jalr            1 = target from ALU (rs1+imm)
//   o_state           current FSM state
//   o_trap            sticky fault flag
//   o_trap_cause      1 illegal, 2 imem timeout, 3 dmem timeout
//   o_instret         retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_control_if.master mem,
   input  logic              i_start,
   input  logic              i_zero,
   input  logic              i_signed_bit,
   output logic [31:0]       o_instr,
   output logic [3:0]        o_alu_op,
   output logic              o_alu_src,
   output logic              o_shift_i,
   output logic              o_reg_we,
   output logic              o_mem_to_reg,
   output logic              o_write_pc4,
   output logic              o_pc_we,
   output logic              o_pc_src,
   output logic              o_jalr,
   output logic [2:0]        o_state,
   output logic              o_trap,
   output logic [1:0]        o_trap_cause,
   output logic [CNT_W-1:0]  o_instret
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_ADD = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // The wait counter only needs to reach MEM_TIMEOUT-1; the last allowed
   // waiting cycle is the one where the counter equals that value.
   localparam int            TW   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [TW-1:0] LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   state_t            r_state;
   state_t            w_nextState;
   logic [31:0]       r_instr;
   logic [CNT_W-1:0]  r_instret;
   logic              r_trap;
   logic [1:0]        r_trapCause;
   logic [TW-1:0]     r_waitCnt;
   logic [1:0]        w_trapCause;
   logic              w_waitExpired;
   logic              w_imemReq;
   logic              w_dmemReq;
   logic              w_dmemWe;

   logic [6:0]        w_op;
   logic [2:0]        w_f3;
   logic [6:0]        w_f7;
   logic              w_isR, w_isI, w_isLw, w_isSw, w_isBr, w_isJal, w_isJalr;
   logic              w_legal, w_taken, w_isShiftI, w_decAluSrc;
   logic [3:0]        w_funcOp, w_decAluOp;

   assign w_op = r_instr[6:0];
   assign w_f3 = r_instr[14:12];
   assign w_f7 = r_instr[31:25];

   assign w_waitExpired = (MEM_TIMEOUT != 0) && (r_waitCnt == LAST);

   // Instruction decode from the latched word: classifies the instruction,
   // flags unsupported encodings, and picks the ALU controls it will use.
   always_comb begin
      w_isR      = (w_op == 7'b0110011);
      w_isI      = (w_op == 7'b0010011);
      w_isLw     = (w_op == 7'b0000011) && (w_f3 == 3'b010);
      w_isSw     = (w_op == 7'b0100011) && (w_f3 == 3'b010);
      w_isBr     = (w_op == 7'b1100011) && (w_f3 != 3'b010) && (w_f3 != 3'b011)
                   && (w_f3 != 3'b110) && (w_f3 != 3'b111);
      w_isJal    = (w_op == 7'b1101111);
      w_isJalr   = (w_op == 7'b1100111) && (w_f3 == 3'b000);
      w_isShiftI = w_isI && ((w_f3 == 3'b001) || (w_f3 == 3'b101));

      w_funcOp = ALU_ADD;
      unique case (w_f3)
         3'b000:  w_funcOp = ALU_ADD;
         3'b001:  w_funcOp = ALU_SLL;
         3'b100:  w_funcOp = ALU_XOR;
         3'b101:  w_funcOp = ALU_SRL;
         3'b110:  w_funcOp = ALU_OR;
         3'b111:  w_funcOp = ALU_AND;
         default: w_funcOp = ALU_ADD;
      endcase

      // slt/sltu and the arithmetic shifts are not supported, so only
      // funct7=0 forms plus R-type sub are legal.
      w_legal = w_isLw || w_isSw || w_isBr || w_isJal || w_isJalr
                || (w_isR && (((w_f7 == 7'b0000000) && (w_f3 != 3'b010) && (w_f3 != 3'b011))
                              || ((w_f7 == 7'b0100000) && (w_f3 == 3'b000))))
                || (w_isI && (w_f3 != 3'b010) && (w_f3 != 3'b011)
                              && (!w_isShiftI || (w_f7 == 7'b0000000)));

      if (w_isBr || (w_isR && w_f7[5])) begin
         w_decAluOp = ALU_SUB;
      end else if (w_isR || w_isI) begin
         w_decAluOp = w_funcOp;
      end else begin
         w_decAluOp = ALU_ADD;
      end
      w_decAluSrc = w_isI || w_isLw || w_isSw || w_isJalr;

      unique case (w_f3)
         3'b000:  w_taken = i_zero;
         3'b001:  w_taken = !i_zero;
         3'b100:  w_taken = !i_zero && i_signed_bit;
         3'b101:  w_taken = !i_signed_bit;
         default: w_taken = 1'b0;
      endcase
   end

   // Next-state and strobe generation. Every strobe defaults low so only the
   // state that owns it can raise it; TRAP therefore drives nothing.
   always_comb begin
      w_nextState  = r_state;
      w_trapCause  = 2'd0;
      w_imemReq    = 1'b0;
      w_dmemReq    = 1'b0;
      w_dmemWe     = 1'b0;
      o_alu_op     = ALU_AND;
      o_alu_src    = 1'b0;
      o_shift_i    = 1'b0;
      o_reg_we     = 1'b0;
      o_mem_to_reg = 1'b0;
      o_write_pc4  = 1'b0;
      o_pc_we      = 1'b0;
      o_pc_src     = 1'b0;
      o_jalr       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) w_nextState = S_FETCH;
         end
         S_FETCH: begin
            w_imemReq = 1'b1;
            if (mem.imem_ready) begin
               w_nextState = S_DECODE;
            end else if (w_waitExpired) begin
               w_nextState = S_TRAP;
               w_trapCause = 2'd2;
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_nextState = S_EXEC;
            end else begin
               w_nextState = S_TRAP;
               w_trapCause = 2'd1;
            end
         end
         S_EXEC: begin
            o_alu_op  = w_decAluOp;
            o_alu_src = w_decAluSrc;
            o_shift_i = w_isShiftI;
            if (w_isBr) begin
               o_pc_we     = 1'b1;
               o_pc_src    = w_taken;
               w_nextState = S_FETCH;
            end else if (w_isJal || w_isJalr) begin
               o_reg_we    = 1'b1;
               o_write_pc4 = 1'b1;
               o_pc_we     = 1'b1;
               o_pc_src    = 1'b1;
               o_jalr      = w_isJalr;
               w_nextState = S_FETCH;
            end else if (w_isLw || w_isSw) begin
               w_nextState = S_MEM;
            end else begin
               w_nextState = S_WB;
            end
         end
         S_MEM: begin
            o_alu_op  = w_decAluOp;
            o_alu_src = w_decAluSrc;
            w_dmemReq = 1'b1;
            w_dmemWe  = w_isSw;
            if (mem.dmem_ready) begin
               if (w_isSw) begin
                  o_pc_we     = 1'b1;
                  w_nextState = S_FETCH;
               end else begin
                  w_nextState = S_WB;
               end
            end else if (w_waitExpired) begin
               w_nextState = S_TRAP;
               w_trapCause = 2'd3;
            end
         end
         S_WB: begin
            o_alu_op     = w_decAluOp;
            o_alu_src    = w_decAluSrc;
            o_shift_i    = w_isShiftI;
            o_reg_we     = 1'b1;
            o_mem_to_reg = w_isLw;
            o_pc_we      = 1'b1;
            w_nextState  = S_FETCH;
         end
         S_TRAP: begin
            w_nextState = S_TRAP;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // State, instruction latch, retire counter, trap capture and wait counter.
   // The wait counter restarts on any state change so each FETCH/MEM visit
   // gets a fresh budget.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_instr     <= 32'd0;
         r_instret   <= '0;
         r_trap      <= 1'b0;
         r_trapCause <= 2'd0;
         r_waitCnt   <= '0;
      end else begin
         r_state <= w_nextState;
         if ((r_state == S_FETCH) && mem.imem_ready) begin
            r_instr <= mem.imem_rdata;
         end
         if (o_pc_we) begin
            r_instret <= r_instret + CNT_W'(1);
         end
         if ((w_nextState == S_TRAP) && (r_state != S_TRAP)) begin
            r_trap      <= 1'b1;
            r_trapCause <= w_trapCause;
         end
         if (w_nextState != r_state) begin
            r_waitCnt <= '0;
         end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
            r_waitCnt <= r_waitCnt + TW'(1);
         end
      end
   end

   assign mem.imem_req  = w_imemReq;
   assign mem.dmem_req  = w_dmemReq;
   assign mem.dmem_we   = w_dmemWe;
   assign o_instr       = r_instr;
   assign o_state       = r_state;
   assign o_trap        = r_trap;
   assign o_trap_cause  = r_trapCause;
   assign o_instret     = r_instret;

endmodule
